// File: rtl/ping_scheduler.sv
// rtl/ping_scheduler.sv - ultrasonic ping sequencer: trigger, echo timing, timeout, fixed ping period
module ping_scheduler #(
    parameter int TRIG_CYCLES    = 120,
    parameter int TIMEOUT_CYCLES = 360000,
    parameter int PERIOD_CYCLES  = 720000,
    parameter int CW             = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          single_shot,
    input  logic          echo,
    output logic          trig,
    output logic          busy,
    output logic          sample_valid,
    output logic [CW-1:0] echo_cycles,
    output logic          timeout,
    output logic [7:0]    sample_count
);

    localparam int PW = $clog2(PERIOD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    if (TRIG_CYCLES < 1 || TRIG_CYCLES + TIMEOUT_CYCLES + 4 >= PERIOD_CYCLES) begin : g_param_check
        $error("ping_scheduler: need TRIG_CYCLES >= 1 and TRIG_CYCLES + TIMEOUT_CYCLES + 4 < PERIOD_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    state_t          state_q, state_d;
    logic            echo_meta_q, echo_meta_d;
    logic            echo_s_q, echo_s_d;
    logic            echo_d_q, echo_d_d;
    logic [PW-1:0]   period_cnt_q, period_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [CW-1:0]   width_cnt_q, width_cnt_d;
    logic [CW-1:0]   echo_cycles_q, echo_cycles_d;
    logic [7:0]      sample_count_q, sample_count_d;
    logic            trig_q, trig_d;
    logic            sample_valid_q, sample_valid_d;
    logic            timeout_q, timeout_d;

    logic            echo_rise;
    logic            period_end;
    logic            trig_end;
    logic            to_end;

    assign echo_rise  = echo_s_q & ~echo_d_q;
    assign period_end = (period_cnt_q == PW'(PERIOD_CYCLES - 1));
    assign trig_end   = (period_cnt_q == PW'(TRIG_CYCLES - 1));
    assign to_end     = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Async reset on every flop so trig drops the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            echo_meta_q    <= 1'b0;
            echo_s_q       <= 1'b0;
            echo_d_q       <= 1'b0;
            period_cnt_q   <= '0;
            to_cnt_q       <= '0;
            width_cnt_q    <= '0;
            echo_cycles_q  <= '0;
            sample_count_q <= '0;
            trig_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            echo_meta_q    <= echo_meta_d;
            echo_s_q       <= echo_s_d;
            echo_d_q       <= echo_d_d;
            period_cnt_q   <= period_cnt_d;
            to_cnt_q       <= to_cnt_d;
            width_cnt_q    <= width_cnt_d;
            echo_cycles_q  <= echo_cycles_d;
            sample_count_q <= sample_count_d;
            trig_q         <= trig_d;
            sample_valid_q <= sample_valid_d;
            timeout_q      <= timeout_d;
        end
    end

    // Timeout wins over a same-cycle rise in WAIT_RISE; an echo fall wins in MEASURE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (enable || single_shot) state_d = S_TRIG;
            S_TRIG:      if (trig_end) state_d = S_WAIT_RISE;
            S_WAIT_RISE: begin
                if (to_end)         state_d = S_HOLDOFF;
                else if (echo_rise) state_d = S_MEASURE;
            end
            S_MEASURE:   if (!echo_s_q || to_end) state_d = S_HOLDOFF;
            S_HOLDOFF:   if (period_end) state_d = enable ? S_TRIG : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        echo_meta_d    = echo;
        echo_s_d       = echo_meta_q;
        echo_d_d       = echo_s_q;
        period_cnt_d   = period_cnt_q + PW'(1);
        to_cnt_d       = '0;
        width_cnt_d    = width_cnt_q;
        sample_valid_d = 1'b0;
        timeout_d      = 1'b0;
        echo_cycles_d  = echo_cycles_q;
        sample_count_d = sample_count_q;
        trig_d         = (state_d == S_TRIG);

        if (state_q == S_IDLE || (state_q == S_HOLDOFF && period_end)) begin
            period_cnt_d = '0;
        end

        case (state_q)
            S_TRIG: width_cnt_d = '0;
            S_WAIT_RISE: begin
                to_cnt_d    = to_cnt_q + TW'(1);
                width_cnt_d = CW'(1);
                timeout_d   = to_end;
            end
            S_MEASURE: begin
                to_cnt_d = to_cnt_q + TW'(1);
                if (!echo_s_q) begin
                    sample_valid_d = 1'b1;
                    echo_cycles_d  = width_cnt_q;
                    sample_count_d = sample_count_q + 8'd1;
                end else begin
                    timeout_d = to_end;
                    if (!(&width_cnt_q)) width_cnt_d = width_cnt_q + CW'(1);
                end
            end
            default: ;
        endcase
    end

    assign trig         = trig_q;
    assign busy         = (state_q != S_IDLE);
    assign sample_valid = sample_valid_q;
    assign echo_cycles  = echo_cycles_q;
    assign timeout      = timeout_q;
    assign sample_count = sample_count_q;

endmodule

// File: tb/tb_ping_scheduler.sv
// tb/tb_ping_scheduler.sv - directed self-checking bench for ping_scheduler
module tb_ping_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        single_shot;
    logic        echo;
    logic        trig;
    logic        busy;
    logic        sample_valid;
    logic [15:0] echo_cycles;
    logic        timeout;
    logic [7:0]  sample_count;

    int n_checks = 0;
    int n_err    = 0;

    int cyc = 0;
    int n_trig = 0, n_sv = 0, n_to = 0;
    int trig_rise_cyc = 0, trig_fall_cyc = 0, trig_period = 0;
    int sv_cyc = 0, to_delta = 0, busy_fall_cyc = 0;
    logic trig_prev = 1'b0, busy_prev = 1'b0;

    int base_trig, base_sv, base_to, mark;

    ping_scheduler #(
        .TRIG_CYCLES(4),
        .TIMEOUT_CYCLES(50),
        .PERIOD_CYCLES(100),
        .CW(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .single_shot(single_shot),
        .echo(echo),
        .trig(trig),
        .busy(busy),
        .sample_valid(sample_valid),
        .echo_cycles(echo_cycles),
        .timeout(timeout),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (trig && !trig_prev) begin
            if (n_trig > 0) trig_period = cyc - trig_rise_cyc;
            trig_rise_cyc = cyc;
            n_trig++;
        end
        if (!trig && trig_prev) trig_fall_cyc = cyc;
        if (sample_valid) begin
            sv_cyc = cyc;
            n_sv++;
        end
        if (timeout) begin
            to_delta = cyc - trig_rise_cyc;
            n_to++;
        end
        if (!busy && busy_prev) busy_fall_cyc = cyc;
        trig_prev = trig;
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_trig(input logic val, input int maxc, input string tag);
        int n = 0;
        while (trig !== val && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(trig), 32'(val));
    endtask

    task automatic wait_sv(input int maxc, input string tag);
        int n = 0;
        while (sample_valid !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sample_valid), 32'd1);
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic pulse_ss();
        single_shot = 1'b1;
        @(negedge clk);
        single_shot = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        single_shot = 1'b0;
        echo        = 1'b0;

        // Reset holds everything at zero regardless of echo activity
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            echo = ~echo;
        end
        tick(1);
        check("rst_trig", 32'(trig), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_sv", 32'(sample_valid), 0);
        check("rst_to", 32'(timeout), 0);
        check("rst_ec", 32'(echo_cycles), 0);
        check("rst_sc", 32'(sample_count), 0);
        echo  = 1'b0;
        rst_n = 1'b1;
        tick(3);

        // Single shot with a 20-clock echo
        base_sv = n_sv;
        mark = cyc;
        pulse_ss();
        check("ss_trig_latency", 32'(trig_rise_cyc - mark), 1);
        check("ss_busy", 32'(busy), 1);
        wait_trig(1'b0, 10, "ss_trig_fall");
        check("ss_trig_width", 32'(trig_fall_cyc - trig_rise_cyc), 4);
        tick(10);
        echo = 1'b1;
        tick(20);
        echo = 1'b0;
        mark = cyc;
        wait_sv(10, "ss_sv_seen");
        check("ss_sv_latency", 32'(sv_cyc - mark), 3);
        check("ss_ec", 32'(echo_cycles), 20);
        check("ss_sc", 32'(sample_count), 1);
        wait_idle(100, "ss_idle");
        check("ss_period", 32'(busy_fall_cyc - trig_rise_cyc), 100);
        check("ss_sv_count", 32'(n_sv - base_sv), 1);

        // Continuous mode, echo low: timeouts every period
        base_sv = n_sv;
        base_to = n_to;
        enable  = 1'b1;
        begin
            int n = 0;
            while (n_to - base_to < 3 && n < 400) begin
                @(negedge clk);
                n++;
            end
        end
        check("to_count", 32'(n_to - base_to), 3);
        check("to_delay", 32'(to_delta), 54);
        check("to_trig_period", 32'(trig_period), 100);
        check("to_no_sample", 32'(n_sv - base_sv), 0);
        check("to_ec_kept", 32'(echo_cycles), 20);
        check("to_sc_kept", 32'(sample_count), 1);
        enable = 1'b0;
        wait_idle(200, "to_idle");

        // Long echo overruns the timeout
        base_sv = n_sv;
        base_to = n_to;
        pulse_ss();
        wait_trig(1'b0, 10, "long_trig_fall");
        tick(5);
        echo = 1'b1;
        tick(60);
        echo = 1'b0;
        wait_idle(100, "long_idle");
        check("long_to_count", 32'(n_to - base_to), 1);
        check("long_to_delay", 32'(to_delta), 54);
        check("long_no_sample", 32'(n_sv - base_sv), 0);
        check("long_ec_kept", 32'(echo_cycles), 20);
        check("long_sc_kept", 32'(sample_count), 1);

        // Stale echo already high at trigger fall
        echo = 1'b1;
        tick(5);
        base_sv = n_sv;
        pulse_ss();
        wait_trig(1'b0, 10, "stale_trig_fall");
        check("stale_echo_high", 32'(echo), 1);
        tick(3);
        echo = 1'b0;
        tick(3);
        echo = 1'b1;
        tick(15);
        echo = 1'b0;
        wait_sv(10, "stale_sv_seen");
        check("stale_ec", 32'(echo_cycles), 15);
        check("stale_sc", 32'(sample_count), 2);
        wait_idle(100, "stale_idle");
        check("stale_sv_count", 32'(n_sv - base_sv), 1);

        // Enable dropped during MEASURE
        base_sv   = n_sv;
        base_trig = n_trig;
        enable    = 1'b1;
        wait_trig(1'b1, 5, "drop_trig_rise");
        wait_trig(1'b0, 10, "drop_trig_fall");
        tick(5);
        echo = 1'b1;
        tick(3);
        enable = 1'b0;
        tick(7);
        echo = 1'b0;
        wait_sv(10, "drop_sv_seen");
        check("drop_ec", 32'(echo_cycles), 10);
        check("drop_sc", 32'(sample_count), 3);
        wait_idle(150, "drop_idle");
        check("drop_busy_fall", 32'(busy_fall_cyc - trig_rise_cyc), 100);
        tick(150);
        check("drop_no_retrig", 32'(n_trig - base_trig), 1);
        check("drop_sv_count", 32'(n_sv - base_sv), 1);

        // 253 more samples wrap sample_count through 255 to 0
        base_sv = n_sv;
        enable  = 1'b1;
        for (int i = 0; i < 253; i++) begin
            wait_trig(1'b1, 120, "wrap_trig_rise");
            wait_trig(1'b0, 10, "wrap_trig_fall");
            tick(2);
            echo = 1'b1;
            tick(5);
            echo = 1'b0;
            if (i == 252) enable = 1'b0;
            wait_sv(10, "wrap_sv_seen");
            if (i == 251) check("wrap_sc_255", 32'(sample_count), 255);
            tick(1);
        end
        wait_idle(150, "wrap_idle");
        check("wrap_sc_0", 32'(sample_count), 0);
        check("wrap_sv_count", 32'(n_sv - base_sv), 253);
        check("wrap_ec", 32'(echo_cycles), 5);

        // Reset while trig is high drops it without a clock edge
        enable = 1'b1;
        wait_trig(1'b1, 5, "rst_mid_trig_high");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_trig", 32'(trig), 0);
        check("rst_mid_busy", 32'(busy), 0);
        enable = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("rst_mid_sc", 32'(sample_count), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ping_scheduler.md
# ping_scheduler

Measurement sequencer for the ultrasonic height sensor. It issues the trigger pulse, synchronizes and times the echo, aborts on a missing or overlong echo, and enforces a fixed ping period. It sits between the sensor pins and the reading/history logic, which consume `echo_cycles` on `sample_valid`. It runs on the 12 MHz oscillator clock.

## Interface

Parameters:
- `TRIG_CYCLES`, default 120: trigger pulse width in clocks (10 µs @ 12 MHz).
- `TIMEOUT_CYCLES`, default 360000: maximum clocks from trigger fall to echo fall (30 ms).
- `PERIOD_CYCLES`, default 720000: clocks between successive trigger rises (60 ms).
- `CW`, default 32: width of `echo_cycles`.
- Constraint: `TRIG_CYCLES + TIMEOUT_CYCLES + 4 < PERIOD_CYCLES`. Elaboration must fail otherwise.

Ports:
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `enable` input, 1 bit: continuous ping mode.
- `single_shot` input, 1 bit: one-cycle pulse requesting one measurement.
- `echo` input, 1 bit: raw sensor echo, asynchronous.
- `trig` output, 1 bit: sensor trigger, registered.
- `busy` output, 1 bit: high in every state except IDLE.
- `sample_valid` output, 1 bit: one-cycle pulse when a new `echo_cycles` value is available.
- `echo_cycles` output, CW bits: last valid echo width in clocks.
- `timeout` output, 1 bit: one-cycle pulse when a measurement is aborted.
- `sample_count` output, 8 bits: count of valid samples, wraps 255→0.

## Operation

- `echo` passes through a 2-flop synchronizer. The output is `echo_s`. All logic uses `echo_s` and its delayed copy `echo_d`.
- States and transitions:
  - **IDLE**: go to TRIG if `enable` or `single_shot`. Set `period_cnt` to 0.
  - **TRIG**: `trig`=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE. Clear `to_cnt`.
  - **WAIT_RISE**: a rising edge (`echo_s`=1, `echo_d`=0) moves to MEASURE. Echo already high on entry is stale and ignored until it falls and rises again.
  - **MEASURE**: `width_cnt` counts cycles with `echo_s`=1. On `echo_s`=0:
    - Latch `width_cnt` into `echo_cycles`.
    - Pulse `sample_valid`.
    - Increment `sample_count`.
    - Go to HOLDOFF.
  - **Timeout**: in WAIT_RISE or MEASURE, when `to_cnt` reaches TIMEOUT_CYCLES-1, pulse `timeout` and go to HOLDOFF. `echo_cycles` and `sample_count` are unchanged.
  - **HOLDOFF**: when `period_cnt` reaches PERIOD_CYCLES-1:
    - If `enable`=1, go to TRIG and reset `period_cnt` to 0.
    - Otherwise go to IDLE.
- `period_cnt` counts from the first TRIG cycle and runs through all non-IDLE states, so the ping rate is fixed regardless of echo length.
- `single_shot` is ignored outside IDLE; requests there are not queued. If `enable` and `single_shot` are both high in IDLE, behaviour is identical to `enable` alone.
- If `enable` drops mid-measurement, the measurement completes and the block returns to IDLE at the period boundary.
- `width_cnt` saturates at all-ones; it cannot overflow for legal parameters.

## Timing

- Reset values: `trig`=0, `busy`=0, `sample_valid`=0, `timeout`=0, `echo_cycles`=0, `sample_count`=0, state IDLE.
- Reset assertion mid-operation drops `trig` immediately, without waiting for a clock edge.
- `trig` rises on the clock edge after `enable`/`single_shot` is sampled in IDLE.
- Trigger rises in continuous mode are exactly PERIOD_CYCLES clocks apart.
- Raw echo edge to `echo_s`: 2 clocks.
- `sample_valid` asserts 1 clock after the first `echo_s`=0 in MEASURE, i.e. 3 clocks after the raw echo fall. `echo_cycles` is stable from that cycle until the next `sample_valid`.
- `echo_cycles` equals the raw echo width in clocks, ±1 for synchronizer phase.
- `timeout` asserts TRIG_CYCLES+TIMEOUT_CYCLES clocks after the trigger rise.

## Test plan

Bench parameters: TRIG_CYCLES=4, TIMEOUT_CYCLES=50, PERIOD_CYCLES=100, CW=16.

- **Reset**: hold `rst_n`=0, toggle `echo` → all outputs 0. Assert reset while `trig`=1 → `trig` drops within the same cycle.
- **Single shot**:
  - Stimulus: `single_shot` pulse; `echo` high for 20 clocks, starting 10 clocks after the `trig` fall.
  - Required: `trig` high for exactly 4 cycles; `sample_valid` 3 clocks after the echo fall; `echo_cycles`=20 (±1); `sample_count`=1; return to IDLE 100 clocks after the `trig` rise.
- **Timeout**: `enable`=1, `echo` held low → `timeout` pulses 54 clocks after each `trig` rise; no `sample_valid`; `echo_cycles` unchanged; `trig` rises every 100 clocks.
- **Long echo**: echo rises 5 clocks after the `trig` fall and stays high for 60 clocks → timeout, no sample.
- **Stale echo**: `echo` already high at the `trig` fall, low 3 clocks later, then high for 15 clocks → `echo_cycles`=15, not 18.
- **Enable drop and wrap**:
  - Deassert `enable` during MEASURE → the sample completes, no further `trig`, `busy` falls at the period boundary.
  - Run 256 valid samples → `sample_count` wraps to 0.
